ami_rd_split: RTL

- User-side read command splitter; sits directly upstream of the AXI master read interface and drives its usr_ar* request port.
- Accepts one large read command (start address plus beat count) and issues a sequence of INCR bursts.
- Each burst is at most BL beats and never crosses a 4KB address boundary.
- Runs entirely in the user clock domain; the read-data return path is not touched.

---
 rtl/ami_rd_split.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ami_rd_split.sv
// ami_rd_split: turns one large user read command into a train of AXI INCR
// read bursts. Each burst is at most BL beats and never crosses a 4KB page.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | cmd_ready high, waiting for a command
//  S_ISSUE | presenting bursts on usr_ar*, one per usr_arready handshake
module ami_rd_split #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int BL         = 16,
  parameter int CMD_LW     = 20
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset_n,
  input  logic [AXI_IW-1:0]     cmd_id,
  input  logic [AXI_AW-1:0]     cmd_addr,
  input  logic [CMD_LW-1:0]     cmd_beats,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  cmd_done,
  output logic                  busy,
  output logic [AXI_IW-1:0]     usr_arid,
  output logic [AXI_AW-1:0]     usr_araddr,
  output logic [AXI_LW-1:0]     usr_arlen,
  output logic [AXI_SW-1:0]     usr_arsize,
  output logic [AXI_BURSTW-1:0] usr_arburst,
  output logic                  usr_arvalid,
  input  logic                  usr_arready
);

  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int NW        = $clog2(BL) + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [AXI_IW-1:0]   id_q, id_d;
  logic [AXI_AW-1:0]   addr_q, addr_d;
  logic [CMD_LW-1:0]   rem_q, rem_d;
  logic [AXI_LW-1:0]   arlen_q, arlen_d;
  logic                arvalid_q, arvalid_d;
  logic                done_q, done_d;

  logic [AXI_AW-1:0]   cmd_addr_al;
  logic [NW-1:0]       cur_n;
  logic [NW-1:0]       nxt_n;
  logic                unused_lsbs;

  // Beats in the next burst: limited by what is left, by BL, and by the
  // distance to the next 4KB page. The page term is 13 bits wide so that a
  // page-aligned address yields a full 4096 bytes.
  function automatic logic [NW-1:0] burst_beats(input logic [11:0] page_off,
                                                input logic [CMD_LW-1:0] rem);
    logic [12:0]   room;
    logic [NW-1:0] n;
    room = (13'h1000 - {1'b0, page_off}) >> L;
    n = NW'(BL);
    if (room < 13'(BL)) n = NW'(room);
    if (rem < CMD_LW'(n)) n = NW'(rem);
    return n;
  endfunction

  assign cmd_addr_al = {cmd_addr[AXI_AW-1:L], {L{1'b0}}};
  assign unused_lsbs = ^cmd_addr[L-1:0];
  assign cur_n       = NW'(arlen_q) + NW'(1);

  // Next-state and next-burst computation.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    done_d    = 1'b0;
    nxt_n     = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          id_d   = cmd_id;
          addr_d = cmd_addr_al;
          rem_d  = cmd_beats;
          if (cmd_beats == '0) begin
            done_d = 1'b1;
          end else begin
            nxt_n     = burst_beats(cmd_addr_al[11:0], cmd_beats);
            arlen_d   = AXI_LW'(nxt_n - NW'(1));
            arvalid_d = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (arvalid_q && usr_arready) begin
          addr_d = addr_q + (AXI_AW'(cur_n) << L);
          rem_d  = rem_q - CMD_LW'(cur_n);
          if (rem_q == CMD_LW'(cur_n)) begin
            arvalid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            nxt_n   = burst_beats(addr_d[11:0], rem_d);
            arlen_d = AXI_LW'(nxt_n - NW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q == S_ISSUE);
  assign cmd_done    = done_q;
  assign usr_arid    = id_q;
  assign usr_araddr  = addr_q;
  assign usr_arlen   = arlen_q;
  assign usr_arvalid = arvalid_q;
  assign usr_arsize  = AXI_SW'(L);
  assign usr_arburst = AXI_BURSTW'(1);

endmodule
